car_lane_ctrl: RTL

//  Multi-lane traffic generator: c_NUM_LANES cars, one per fixed-Y lane.
//  - Each lane has its own direction and speed divider; speed level is selectable at run time.
//  - A car that exits the screen waits a pseudo-random gap, then respawns at its entry edge.
//  - Produces a registered sprite draw flag and a player collision flag for the VGA pixel pipeline.
//  - Sits beside the player controller; generalises the single-car controller.

---
 rtl/car_lane_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/car_lane_ctrl.sv
// Multi-lane traffic generator: one car per fixed-Y lane, each with its own direction and
// step divider, pseudo-random respawn gap, and registered sprite-draw / player-collision flags.
module car_lane_ctrl #(
  parameter int          c_GAME_WIDTH  = 640,
  parameter int          c_GAME_HEIGHT = 480,
  parameter int          c_NUM_LANES   = 4,
  parameter int          c_CAR_W       = 32,
  parameter int          c_CAR_H       = 32,
  parameter int          c_LANE_Y0     = 96,
  parameter int          c_LANE_PITCH  = 64,
  parameter logic [7:0]  c_DIR_MASK    = 8'hAA,
  parameter int          c_BASE_TICK   = 165000,
  parameter logic [15:0] c_LFSR_SEED   = 16'hACE1
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic                       i_Game_Active,
  input  logic [1:0]                 i_Speed_Lvl,
  input  logic [9:0]                 i_Col_Count_Div,
  input  logic [9:0]                 i_Row_Count_Div,
  input  logic [9:0]                 i_Player_X,
  input  logic [9:0]                 i_Player_Y,
  output logic [10*c_NUM_LANES-1:0]  o_Car_X,
  output logic [c_NUM_LANES-1:0]     o_Car_Active,
  output logic                       o_Draw_Car,
  output logic                       o_Collision
);
  localparam int TW = $clog2(c_BASE_TICK + 1);

  typedef enum logic {S_MOVE, S_WAIT} lane_state_t;

  if (c_GAME_WIDTH > 1023 || c_GAME_HEIGHT > 1023 || c_NUM_LANES < 1 || c_NUM_LANES > 8) begin : g_bad_params
    $error("car_lane_ctrl: parameter out of range");
  end

  logic [TW-1:0]          tick_cnt, tick_last;
  logic                   tick, park;
  logic [15:0]            lfsr;
  logic [c_NUM_LANES-1:0] draw_hit, col_hit;
  logic [10:0]            col, row, px, py;

  assign park      = !i_Game_Active;
  assign tick_last = (TW'(c_BASE_TICK) >> i_Speed_Lvl) - TW'(1);
  // >= rather than == so a speed-up past the current count ticks at once and wraps
  assign tick      = tick_cnt >= tick_last;

  assign col = {1'b0, i_Col_Count_Div};
  assign row = {1'b0, i_Row_Count_Div};
  assign px  = {1'b0, i_Player_X};
  assign py  = {1'b0, i_Player_Y};

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      tick_cnt <= '0;
      lfsr     <= c_LFSR_SEED;
    end else if (park) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      lfsr     <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  for (genvar k = 0; k < c_NUM_LANES; k++) begin : g_lane
    localparam logic [9:0]  X_PARK  = 10'((k * c_GAME_WIDTH) / c_NUM_LANES);
    localparam logic [9:0]  X_SPAWN = c_DIR_MASK[k] ? 10'd0 : 10'(c_GAME_WIDTH - 1);
    localparam logic [9:0]  X_EXIT  = c_DIR_MASK[k] ? 10'(c_GAME_WIDTH - 1) : 10'd0;
    localparam logic [10:0] Y_TOP   = 11'(c_LANE_Y0 + k * c_LANE_PITCH);
    localparam logic [10:0] Y_BOT   = 11'(c_LANE_Y0 + k * c_LANE_PITCH + c_CAR_H);

    lane_state_t state, state_nxt;
    logic [9:0]  x, x_nxt;
    logic [2:0]  div, div_nxt;
    logic [6:0]  gap, gap_nxt;
    logic [10:0] x_lo, x_hi;
    logic        active;

    always_comb begin
      state_nxt = state;
      x_nxt     = x;
      div_nxt   = div;
      gap_nxt   = gap;
      if (tick) begin
        if (state == S_MOVE) begin
          if (div == 3'(k)) begin
            div_nxt = '0;
            if (x == X_EXIT) begin
              state_nxt = S_WAIT;
              gap_nxt   = 7'd8 + {1'b0, lfsr[5:0] ^ 6'(k)};
            end else begin
              x_nxt = c_DIR_MASK[k] ? x + 10'd1 : x - 10'd1;
            end
          end else begin
            div_nxt = div + 3'd1;
          end
        end else if (gap <= 7'd1) begin
          // gap counts whole ticks; the divider is bypassed while waiting
          state_nxt = S_MOVE;
          x_nxt     = X_SPAWN;
          gap_nxt   = '0;
        end else begin
          gap_nxt = gap - 7'd1;
        end
      end
    end

    always_ff @(posedge i_Clk) begin
      if (i_Rst || park) begin
        state <= S_MOVE;
        x     <= X_PARK;
        div   <= '0;
        gap   <= '0;
      end else begin
        state <= state_nxt;
        x     <= x_nxt;
        div   <= div_nxt;
        gap   <= gap_nxt;
      end
    end

    assign active = (state == S_MOVE);
    assign x_lo   = {1'b0, x};
    assign x_hi   = x_lo + 11'(c_CAR_W);

    assign draw_hit[k] = active && col >= x_lo && col < x_hi && row >= Y_TOP && row < Y_BOT;
    // strict compares on both sides: abutting boxes do not collide
    assign col_hit[k]  = active && px < x_hi && x_lo < px + 11'(c_CAR_W) &&
                         py < Y_BOT && Y_TOP < py + 11'(c_CAR_H);

    assign o_Car_X[10*k +: 10] = x;
    assign o_Car_Active[k]     = active;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Draw_Car  <= 1'b0;
      o_Collision <= 1'b0;
    end else begin
      o_Draw_Car  <= |draw_hit;
      o_Collision <= |col_hit;
    end
  end
endmodule
